// File: rtl/maxpool_l1_if.sv
`default_nettype none
// ============================================================================
// maxpool_l1_if : control and buffer A/B port bundle for the L1 max-pool block
// Revision 1.0
// ============================================================================
interface maxpool_l1_if;
   logic        start;
   logic        busy;
   logic        done;
   logic [13:0] buf_a_addr;
   logic [7:0]  buf_a_rd_data;
   logic [11:0] buf_b_addr;
   logic [7:0]  buf_b_wr_data;
   logic        buf_b_wr_en;

   modport master (
      output start, buf_a_rd_data,
      input  busy, done, buf_a_addr, buf_b_addr, buf_b_wr_data, buf_b_wr_en
   );

   modport slave (
      input  start, buf_a_rd_data,
      output busy, done, buf_a_addr, buf_b_addr, buf_b_wr_data, buf_b_wr_en
   );
endinterface
`default_nettype wire

// File: rtl/maxpool_l1.sv
`default_nettype none
// ============================================================================
// maxpool_l1 : 2x2/stride-2 signed int8 max-pool sequencer, buffer A -> buffer B
// Revision 1.0
// ============================================================================
module maxpool_l1 #(
   parameter int CH    = 16,
   parameter int IN_W  = 26,
   parameter int OUT_W = 13
) (
   input  logic          clk,
   input  logic          rst,
   maxpool_l1_if.slave   pool_bus
);

   localparam int          c_XW       = $clog2(OUT_W);
   localparam int          c_CW       = (CH > 1) ? $clog2(CH) : 1;
   localparam logic [13:0] c_ROW      = 14'(IN_W);
   localparam logic [13:0] c_ROW_STEP = 14'(IN_W + 2);
   localparam logic [c_XW-1:0] c_X_LAST = c_XW'(OUT_W - 1);
   localparam logic [c_CW-1:0] c_C_LAST = c_CW'(CH - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_A0   = 3'd1,
      S_A1   = 3'd2,
      S_A2   = 3'd3,
      S_A3   = 3'd4,
      S_WR   = 3'd5,
      S_DONE = 3'd6
   } state_t;

   state_t          state_q, state_d;
   logic [13:0]     p0_q, p0_d;
   logic [13:0]     a_addr_q, a_addr_d;
   logic [11:0]     out_q, out_d;
   logic [c_XW-1:0] ox_q, ox_d, oy_q, oy_d;
   logic [c_CW-1:0] c_q, c_d;
   logic [7:0]      m_q, m_d;

   logic [7:0]      rd_data;
   logic [7:0]      tap_max;
   logic            ox_last, oy_last, pass_last;
   logic            wr_en;
   logic [7:0]      wr_data;

   assign rd_data   = pool_bus.buf_a_rd_data;
   assign tap_max   = ($signed(rd_data) > $signed(m_q)) ? rd_data : m_q;
   assign ox_last   = (ox_q == c_X_LAST);
   assign oy_last   = (oy_q == c_X_LAST);
   assign pass_last = ox_last && oy_last && (c_q == c_C_LAST);

   always_comb begin
      state_d  = state_q;
      p0_d     = p0_q;
      a_addr_d = a_addr_q;
      out_d    = out_q;
      ox_d     = ox_q;
      oy_d     = oy_q;
      c_d      = c_q;
      m_d      = m_q;
      wr_en    = 1'b0;
      wr_data  = 8'h00;

      case (state_q)
         S_IDLE: begin
            if (pool_bus.start) begin
               p0_d    = '0;
               out_d   = '0;
               ox_d    = '0;
               oy_d    = '0;
               c_d     = '0;
               state_d = S_A0;
            end
         end
         S_A0: begin
            a_addr_d = p0_q;
            state_d  = S_A1;
         end
         S_A1: begin
            a_addr_d = p0_q + 14'd1;
            m_d      = rd_data;
            state_d  = S_A2;
         end
         S_A2: begin
            a_addr_d = p0_q + c_ROW;
            m_d      = tap_max;
            state_d  = S_A3;
         end
         S_A3: begin
            a_addr_d = p0_q + c_ROW + 14'd1;
            m_d      = tap_max;
            state_d  = S_WR;
         end
         S_WR: begin
            wr_en   = 1'b1;
            wr_data = tap_max;
            // Counters freeze on the final output so buf_b_addr never passes the last index.
            if (pass_last) begin
               state_d = S_DONE;
            end else begin
               state_d = S_A0;
               out_d   = out_q + 12'd1;
               if (ox_last) begin
                  ox_d = '0;
                  p0_d = p0_q + c_ROW_STEP;
                  if (oy_last) begin
                     oy_d = '0;
                     c_d  = c_q + c_CW'(1);
                  end else begin
                     oy_d = oy_q + c_XW'(1);
                  end
               end else begin
                  ox_d = ox_q + c_XW'(1);
                  p0_d = p0_q + 14'd2;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         p0_q     <= '0;
         a_addr_q <= '0;
         out_q    <= '0;
         ox_q     <= '0;
         oy_q     <= '0;
         c_q      <= '0;
         m_q      <= '0;
      end else begin
         state_q  <= state_d;
         p0_q     <= p0_d;
         a_addr_q <= a_addr_d;
         out_q    <= out_d;
         ox_q     <= ox_d;
         oy_q     <= oy_d;
         c_q      <= c_d;
         m_q      <= m_d;
      end
   end

   // Write strobe is masked by rst so a reset landing on a WR cycle never commits a write.
   assign pool_bus.buf_b_wr_en   = wr_en && !rst;
   assign pool_bus.buf_b_wr_data = wr_data;
   assign pool_bus.buf_b_addr    = out_q;
   assign pool_bus.buf_a_addr    = a_addr_d;
   assign pool_bus.busy          = (state_q != S_IDLE) && (state_q != S_DONE);
   assign pool_bus.done          = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_maxpool_l1.sv
`default_nettype none
// ============================================================================
// tb_maxpool_l1 : self-checking bench for maxpool_l1 against a window-max model
// Revision 1.0
// ============================================================================
module tb_maxpool_l1;

   localparam int c_NA   = 16 * 26 * 26;
   localparam int c_NB   = 16 * 13 * 13;
   localparam int c_PASS = c_NB * 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   maxpool_l1_if bus ();

   maxpool_l1 #(.CH(16), .IN_W(26), .OUT_W(13)) dut (
      .clk      (clk),
      .rst      (rst),
      .pool_bus (bus)
   );

   logic [7:0] mem_a  [c_NA];
   logic [7:0] mem_b  [c_NB];
   logic [7:0] ref_b  [c_NB];
   logic [7:0] save_b [c_NB];

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int s_edge   = 0;
   int off, wr_cnt, first_wr, last_wr, last_addr, seq_err, busy_cnt;
   int a_max, b_max, done_off, done_cnt;
   logic busy_at_done;

   // Buffer A: single port, one-cycle read latency
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (int'(bus.buf_a_addr) < c_NA) bus.buf_a_rd_data <= mem_a[bus.buf_a_addr];
      else                             bus.buf_a_rd_data <= 8'hxx;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      off = 0; wr_cnt = 0; first_wr = -1; last_wr = -1; last_addr = -1; seq_err = 0;
      busy_cnt = 0; a_max = 0; b_max = 0; done_off = -1; done_cnt = 0; busy_at_done = 1'bx;
   endtask

   // One cycle of observation, sampled on the falling edge.
   task automatic tick();
      @(negedge clk);
      off = cyc - s_edge + 1;
      if (int'(bus.buf_a_addr) > a_max) a_max = int'(bus.buf_a_addr);
      if (int'(bus.buf_b_addr) > b_max) b_max = int'(bus.buf_b_addr);
      if (bus.buf_b_wr_en === 1'b1) begin
         if (int'(bus.buf_b_addr) < c_NB) mem_b[bus.buf_b_addr] = bus.buf_b_wr_data;
         if (wr_cnt == 0) first_wr = off;
         last_wr   = off;
         last_addr = int'(bus.buf_b_addr);
         if (int'(bus.buf_b_addr) != wr_cnt) seq_err++;
         wr_cnt++;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
         done_cnt++;
         done_off     = off;
         busy_at_done = bus.busy;
      end
   endtask

   task automatic start_pass();
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      s_edge    = cyc;
      bus.start = 1'b0;
   endtask

   task automatic run_pass(input bit extra_starts);
      clear_stats();
      start_pass();
      for (int k = 0; k < c_PASS + 40 && done_cnt == 0; k++) begin
         tick();
         if (extra_starts) bus.start = (off == 3000) || (bus.done === 1'b1);
      end
      chk("done_seen", done_cnt, 1);
      if (extra_starts) begin
         tick();
         bus.start = 1'b0;
      end
   endtask

   task automatic check_timing(input string tag);
      chk({tag, "_done_cycle"}, done_off, c_PASS + 1);
      chk({tag, "_first_wr"}, first_wr, 5);
      chk({tag, "_last_wr"}, last_wr, c_PASS);
      chk({tag, "_wr_count"}, wr_cnt, c_NB);
      chk({tag, "_wr_seq_err"}, seq_err, 0);
      chk({tag, "_last_addr"}, last_addr, c_NB - 1);
      chk({tag, "_busy_cycles"}, busy_cnt, c_PASS);
      chk({tag, "_busy_at_done"}, busy_at_done, 0);
   endtask

   task automatic compute_ref();
      int taps [4];
      taps = '{0, 1, 26, 27};
      for (int c = 0; c < 16; c++)
         for (int oy = 0; oy < 13; oy++)
            for (int ox = 0; ox < 13; ox++) begin
               int p, best, v;
               p    = c * 676 + (2 * oy) * 26 + 2 * ox;
               best = -1000;
               for (int t = 0; t < 4; t++) begin
                  v = int'($signed(mem_a[p + taps[t]]));
                  if (v > best) best = v;
               end
               ref_b[c * 169 + oy * 13 + ox] = 8'(best);
            end
   endtask

   task automatic compare_b(input string tag, input bit vs_saved);
      int bad;
      logic [7:0] e;
      bad = 0;
      for (int i = 0; i < c_NB; i++) begin
         e = vs_saved ? save_b[i] : ref_b[i];
         if (mem_b[i] !== e) bad++;
      end
      chk(tag, bad, 0);
   endtask

   task automatic clear_b();
      for (int i = 0; i < c_NB; i++) mem_b[i] = 8'hxx;
   endtask

   task automatic fill_random();
      for (int i = 0; i < c_NA; i++) mem_a[i] = 8'($urandom);
   endtask

   initial begin
      int w0, prev_s;
      bus.start = 1'b0;
      clear_stats();
      clear_b();
      for (int i = 0; i < c_NA; i++) mem_a[i] = 8'h00;

      // Reset state
      repeat (3) tick();
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_wr_en", bus.buf_b_wr_en, 0);
      chk("rst_wr_data", bus.buf_b_wr_data, 0);
      chk("rst_a_addr", bus.buf_a_addr, 0);
      chk("rst_b_addr", bus.buf_b_addr, 0);
      rst = 1'b0;
      repeat (3) tick();
      chk("idle_busy", bus.busy, 0);

      // Ramp pass, with stray starts mid-run and on the done cycle
      for (int i = 0; i < c_NA; i++) mem_a[i] = 8'(i % 128);
      compute_ref();
      run_pass(1'b1);
      check_timing("ramp");
      chk("ramp_b0", mem_b[0], 27);
      chk("ramp_b1", mem_b[1], 29);
      chk("ramp_b13", mem_b[13], 79);
      chk("ramp_a_addr_max", a_max, c_NA - 1);
      chk("ramp_b_addr_max", b_max, c_NB - 1);
      compare_b("ramp_full", 1'b0);
      w0 = wr_cnt;
      repeat (60) tick();
      chk("no_second_pass_wr", wr_cnt, w0);
      chk("no_second_pass_busy", bus.busy, 0);

      // Random data with signed, channel-boundary and last-window directed taps
      fill_random();
      mem_a[0]  = 8'h80; mem_a[1]  = 8'hFF; mem_a[26] = 8'hFB; mem_a[27] = 8'h9C;
      mem_a[2]  = 8'h7F; mem_a[3]  = 8'h80; mem_a[28] = 8'h00; mem_a[29] = 8'h01;
      mem_a[648] = 8'h11; mem_a[649] = 8'h22; mem_a[674] = 8'h33; mem_a[675] = 8'h44;
      mem_a[676] = 8'hF0; mem_a[677] = 8'hF1; mem_a[702] = 8'hF2; mem_a[703] = 8'hF3;
      mem_a[10788] = 8'd5; mem_a[10789] = 8'd9; mem_a[10814] = 8'd3; mem_a[10815] = 8'd7;
      compute_ref();
      clear_b();
      run_pass(1'b0);
      check_timing("rand");
      chk("signed_b0", mem_b[0], 8'hFF);
      chk("signed_b1", mem_b[1], 8'h7F);
      chk("chan_b168", mem_b[168], 8'h44);
      chk("chan_b169", mem_b[169], 8'hF3);
      chk("last_b2703", mem_b[2703], 9);
      compare_b("rand_full", 1'b0);

      // Reset mid-run
      fill_random();
      clear_stats();
      start_pass();
      for (int k = 0; k < 6000 && off < 4999; k++) tick();
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
      tick();
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_wr_en", bus.buf_b_wr_en, 0);
      repeat (3) tick();
      rst = 1'b0;
      repeat (50) tick();
      chk("midrst_wr_count", wr_cnt, 999);
      chk("midrst_busy_cycles", busy_cnt, 5000);

      // Full pass after reset, then a back-to-back repeat at the earliest restart
      fill_random();
      compute_ref();
      clear_b();
      run_pass(1'b0);
      check_timing("postrst");
      compare_b("postrst_full", 1'b0);
      for (int i = 0; i < c_NB; i++) save_b[i] = mem_b[i];
      prev_s = s_edge;
      clear_b();
      run_pass(1'b0);
      chk("b2b_restart_gap", s_edge - prev_s, c_PASS + 2);
      check_timing("b2b");
      compare_b("b2b_identical", 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/maxpool_l1.md
# maxpool_l1

Layer-1 2×2/stride-2 max-pool sequencer for the CNN inference datapath. On `start`, it reads the 16×26×26 signed int8 L1 conv output from buffer A through the single-port, 1-cycle-read-latency port of `ram_cnn`. It writes the 16×13×13 pooled result into buffer B, then pulses `done`. It sits between the L1 conv engine, which fills buffer A, and the L2 conv engine, which consumes buffer B.

## Interface
Parameters:
- `CH`, 16, channel count
- `IN_W`, 26, input width and height
- `OUT_W`, 13, output width and height (= `IN_W`/2)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin one full pooling pass; sampled only in IDLE
- `busy`  out  1  high while a pass is in progress
- `done`  out  1  one-cycle pulse when the pass completes
- `buf_a_addr`  out  14  read address into buffer A
- `buf_a_rd_data`  in  8  buffer A data; valid the cycle after its address is driven
- `buf_b_addr`  out  12  write address into buffer B
- `buf_b_wr_data`  out  8  pooled value
- `buf_b_wr_en`  out  1  buffer B write strobe

## Operation
- Memory layouts are channel-major.
  - Input address: c·676 + y·26 + x.
  - Output address: c·169 + oy·13 + ox.
- Iteration order: ox fastest, then oy, then c.
- Window base `p0` = c·676 + 2·oy·26 + 2·ox. The four window taps are `p0`, `p0+1`, `p0+26`, `p0+27`.
- `p0` is kept as a running register, not recomputed by multiplication:
  - +2 after each output.
  - +28 when ox = 12. This covers both row wrap and channel wrap, since 676 − 648 = 28.
- Output index is a running 12-bit counter, incremented by 1 per output.
- Comparison is signed 8-bit. The running max `m` is an 8-bit register. No saturation is needed.
- States:
  - IDLE: `busy`=0. On `start`=1: `p0`←0, out index←0, ox/oy/c←0, go to A0.
  - A0: drive `buf_a_addr`=`p0`. Go to A1.
  - A1: drive `p0+1`; `m`←`buf_a_rd_data` (tap 0). Go to A2.
  - A2: drive `p0+26`; `m`←max(`m`, rd_data) (tap 1). Go to A3.
  - A3: drive `p0+27`; `m`←max(`m`, rd_data) (tap 2). Go to WR.
  - WR: `buf_b_wr_en`=1; `buf_b_wr_data`=max(`m`, rd_data) (tap 3, combinational); `buf_b_addr`=out index; advance counters.
    - If this was the last output (c=15, oy=12, ox=12): go to DONE.
    - Otherwise: go to A0.
  - DONE: `done`=1, `busy`=0. Go to IDLE.
- `start` is ignored in every state except IDLE, including DONE.
- `buf_b_addr` holds the current out index in all states. `buf_a_addr` holds its last driven value outside A0–A3.
- `rst` in any state:
  - Go to IDLE; clear all counters and `m`.
  - No write is issued in the reset cycle or after it.
  - The partial buffer B contents are left as is.

## Timing
- Reset values: `busy`=0, `done`=0, `buf_b_wr_en`=0, `buf_b_wr_data`=0, `buf_a_addr`=0, `buf_b_addr`=0.
- Each output takes 5 cycles (A0..WR). A pass is 16·169·5 = 13520 busy cycles.
- If `start` is sampled high at edge T:
  - `busy` is high on cycles T+1 .. T+13520.
  - The first `buf_b_wr_en` is on cycle T+5.
  - The last write is on cycle T+13520, to address 2703.
  - `done` is high on cycle T+13521 only.
  - The earliest accepted restart is `start` sampled at T+13522.
- Exactly 2704 writes per pass. Write addresses are strictly increasing 0..2703 with no gaps or repeats.
- Address bounds: max `buf_a_addr` = 15·676+648+27 = 10815; max `buf_b_addr` = 2703. Neither output ever exceeds these.

## Test plan
- Ramp: buffer A[i] = i mod 128, one start → B[0]=27, B[1]=29, B[13]=79; the exact result is checked against a reference model for all 2704 entries.
- Signed window: taps {0x80, 0xFF, 0xFB, 0x9C} at output 0 → B[0]=0xFF (−1). Taps {0x7F, 0x80, 0x00, 0x01} → 0x7F.
- Boundary window: A[10788]=5, A[10789]=9, A[10814]=3, A[10815]=7 → B[2703]=9. Also confirm that channel-boundary outputs 168/169 read the correct taps (`p0`=648 and `p0`=676).
- Cycle count: start at T → `done` exactly at T+13521, 2704 wr_en pulses, `busy` low on the `done` cycle. A `start` pulsed during the run or on the `done` cycle causes no second pass.
- Reset mid-run: assert `rst` at T+5000 → next cycle `busy`=0 and `wr_en`=0, with no further writes. A new start then produces a full, correct 2704-entry pass from address 0.
- Back-to-back: a second start at T+13522 reproduces identical buffer B contents and identical timing.
